// File: rtl/acc_in_loader_if.sv
// +----------------------------------------------------------------------+
// | acc_in_loader_if : byte stream in, 4-byte vector out handshakes       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface acc_in_loader_if;
  logic signed [7:0] din;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic signed [7:0] X1;
  logic signed [7:0] X2;
  logic signed [7:0] X3;
  logic signed [7:0] X4;
  logic              valid;
  logic              ready;

  // master: the loader; slave: byte source plus accelerator side
  modport master (
    input  din, din_valid, din_last, ready,
    output din_ready, X1, X2, X3, X4, valid
  );

  modport slave (
    output din, din_valid, din_last, ready,
    input  din_ready, X1, X2, X3, X4, valid
  );
endinterface

`default_nettype wire

// File: rtl/acc_in_loader.sv
// +----------------------------------------------------------------------+
// | acc_in_loader : frames signed bytes into X1..X4 with double buffering |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module acc_in_loader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  acc_in_loader_if.master  bus,
  input  logic             err_clr,
  output logic             err,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [3:0][7:0]  r_asm;
  logic [3:0][7:0]  r_x;
  logic             r_valid;
  logic             r_din_ready;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_out_free;
  logic w_acc;
  logic w_take;

  assign w_out_free = !r_valid || bus.ready;
  assign w_acc      = bus.din_valid && r_din_ready;
  assign w_take     = r_valid && bus.ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_asm       <= '0;
      r_x         <= '0;
      r_valid     <= 1'b0;
      r_din_ready <= 1'b1;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_take) begin
        r_valid <= 1'b0;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // later framing-error assignments override this clear
      if (err_clr) r_err <= 1'b0;

      case (r_state)
        IDLE, FILL: begin
          if (w_acc) begin
            if (r_idx != 2'd3) begin
              if (bus.din_last) begin
                r_err   <= 1'b1;
                r_idx   <= 2'd0;
                r_state <= IDLE;
              end else begin
                r_asm[r_idx] <= bus.din;
                r_idx        <= r_idx + 2'd1;
                r_state      <= FILL;
              end
            end else if (bus.din_last) begin
              r_idx <= 2'd0;
              if (w_out_free) begin
                r_x     <= {bus.din, r_asm[2], r_asm[1], r_asm[0]};
                r_valid <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_asm[3]    <= bus.din;
                r_state     <= FULL;
                r_din_ready <= 1'b0;
              end
            end else begin
              r_err   <= 1'b1;
              r_idx   <= 2'd0;
              r_state <= DROP;
            end
          end
        end
        FULL: begin
          if (w_out_free) begin
            r_x         <= r_asm;
            r_valid     <= 1'b1;
            r_din_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        DROP: begin
          if (w_acc && bus.din_last) r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.X1        = r_x[0];
  assign bus.X2        = r_x[1];
  assign bus.X3        = r_x[2];
  assign bus.X4        = r_x[3];
  assign bus.valid     = r_valid;
  assign bus.din_ready = r_din_ready;
  assign err           = r_err;
  assign vec_cnt       = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_acc_in_loader.sv
// +----------------------------------------------------------------------+
// | tb_acc_in_loader : table vectors, corner sequences, random vs model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_acc_in_loader;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             err_clr = 1'b0;
  logic             err;
  logic [CNT_W-1:0] vec_cnt;

  acc_in_loader_if bus();

  acc_in_loader #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err     (err),
    .vec_cnt (vec_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  bit g_rdy  = 1'b0;
  logic [31:0] got_q[$];

  // frame-level reference: partial frame, drop flag, one pending vector
  logic [7:0]  m_cur[$];
  logic [31:0] m_pend[$];
  bit          m_drop;
  logic [31:0] m_out;
  bit          m_ov;
  bit          m_err;
  int          m_cnt;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] xp();
    return {bus.X1, bus.X2, bus.X3, bus.X4};
  endfunction

  task automatic model_reset();
    m_cur.delete(); m_pend.delete();
    m_drop = 0; m_out = '0; m_ov = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit take, free, acc, fe;
    take = m_ov && bus.ready;
    free = !m_ov || bus.ready;
    acc  = bus.din_valid && (m_pend.size() == 0);
    fe   = 0;
    if (take) begin m_cnt = (m_cnt + 1) % (1 << CNT_W); m_ov = 0; end
    if (m_pend.size() > 0 && free) begin
      m_out = m_pend.pop_front(); m_ov = 1;
    end
    if (acc) begin
      if (m_drop) begin
        if (bus.din_last) m_drop = 0;
      end else begin
        m_cur.push_back(bus.din);
        if (m_cur.size() == 4) begin
          if (bus.din_last) begin
            if (free) begin m_out = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]}; m_ov = 1; end
            else m_pend.push_back({m_cur[0], m_cur[1], m_cur[2], m_cur[3]});
          end else begin
            fe = 1; m_drop = 1;
          end
          m_cur.delete();
        end else if (bus.din_last) begin
          fe = 1; m_cur.delete();
        end
      end
    end
    if (err_clr) m_err = 0;
    if (fe) m_err = 1;
  endtask

  task automatic check_model(string tag);
    chk({tag, " din_ready"}, bus.din_ready, m_pend.size() == 0);
    chk({tag, " valid"}, bus.valid, m_ov);
    chk({tag, " X"}, xp(), m_out);
    chk({tag, " err"}, err, m_err);
    chk({tag, " vec_cnt"}, vec_cnt, m_cnt);
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cycle(bit dv, logic [7:0] d, bit last, bit rdy, bit clr);
    bus.din_valid = dv; bus.din = d; bus.din_last = last;
    bus.ready = rdy; err_clr = clr;
    if (bus.valid && rdy) got_q.push_back(xp());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.din_valid = 0; bus.din = '0; bus.din_last = 0; bus.ready = 0; err_clr = 0;
    arst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1;
    got_q.delete();
  endtask

  task automatic send_byte(logic [7:0] d, bit last);
    bit a;
    for (int n = 0; n < 100; n++) begin
      a = bus.din_ready;
      cycle(1, d, last, g_rdy, 0);
      check_model("stream");
      if (a) return;
    end
    chk("din_ready timeout", 0, 1);
  endtask

  task automatic send_frame(logic [31:0] v);
    send_byte(v[31:24], 0);
    send_byte(v[23:16], 0);
    send_byte(v[15:8], 0);
    send_byte(v[7:0], 1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 8'h00, 0, g_rdy, 0);
      check_model("idle");
    end
  endtask

  typedef struct {
    bit dv; logic [7:0] d; bit last; bit rdy; bit clr;
    bit e_valid; logic [31:0] e_x; bit e_err; logic [3:0] e_cnt; bit e_drdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int pos;
    bit dv, last, a;

    tbl = '{
      '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b1},
      '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b1},
      '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b1},
      '{1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10F07F81, 1'b0, 4'd0, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10F07F81, 1'b0, 4'd1, 1'b1},
      '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10F07F81, 1'b0, 4'd1, 1'b1},
      '{1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10F07F81, 1'b1, 4'd1, 1'b1},
      '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10F07F81, 1'b1, 4'd1, 1'b1},
      '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10F07F81, 1'b1, 4'd1, 1'b1},
      '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10F07F81, 1'b1, 4'd1, 1'b1},
      '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 32'h01020304, 1'b1, 4'd1, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h01020304, 1'b0, 4'd2, 1'b1}
    };

    // reset state and table vectors
    do_reset();
    chk("reset valid", bus.valid, 0);
    chk("reset X", xp(), 0);
    chk("reset err", err, 0);
    chk("reset vec_cnt", vec_cnt, 0);
    chk("reset din_ready", bus.din_ready, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].dv, tbl[i].d, tbl[i].last, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl[%0d] valid", i), bus.valid, tbl[i].e_valid);
      chk($sformatf("tbl[%0d] X", i), xp(), tbl[i].e_x);
      chk($sformatf("tbl[%0d] err", i), err, tbl[i].e_err);
      chk($sformatf("tbl[%0d] vec_cnt", i), vec_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl[%0d] din_ready", i), bus.din_ready, tbl[i].e_drdy);
      if (i == 3) chk("X2 signed", 64'($signed(int'($signed(bus.X2)))), 64'($signed(-16)));
    end

    // backpressure: three frames, accelerator stalled
    do_reset();
    g_rdy = 0;
    send_frame(32'hA1A2A3A4);
    send_frame(32'hB1B2B3B4);
    chk("bp din_ready 9th byte", bus.din_ready, 0);
    chk("bp X held", xp(), 32'hA1A2A3A4);
    chk("bp valid held", bus.valid, 1);
    g_rdy = 1;
    send_frame(32'hC1C2C3C4);
    idle(3);
    chk("bp vec_cnt", vec_cnt, 3);
    chk("bp count delivered", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp order 0", got_q[0], 32'hA1A2A3A4);
      chk("bp order 1", got_q[1], 32'hB1B2B3B4);
      chk("bp order 2", got_q[2], 32'hC1C2C3C4);
    end

    // long frame, DROP resync, err_clr
    do_reset();
    g_rdy = 1;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    chk("long err", err, 1);
    send_frame(32'h11223344);
    idle(2);
    chk("long delivered", got_q.size(), 1);
    if (got_q.size() == 1) chk("long data", got_q[0], 32'h11223344);
    cycle(0, 8'h00, 0, 1, 1);
    chk("long err_clr", err, 0);

    // err_clr coincident with a short-frame error: set wins
    send_byte(8'h55, 0);
    bus.din_valid = 1; bus.din = 8'h66; bus.din_last = 1; err_clr = 1;
    @(posedge clk); model_step(); @(negedge clk);
    chk("err set wins", err, 1);
    check_model("set wins");

    // counter wrap with CNT_W=4
    do_reset();
    g_rdy = 1;
    for (int i = 0; i < 17; i++) send_frame(32'h01000000 * i + 32'h00102030);
    idle(2);
    chk("wrap vec_cnt", vec_cnt, 1);

    // async reset while FULL
    do_reset();
    g_rdy = 1;
    send_frame(32'h0A0B0C0D);
    idle(1);
    send_byte(8'h01, 1);
    g_rdy = 0;
    send_frame(32'h21222324);
    send_frame(32'h31323334);
    chk("pre-reset din_ready", bus.din_ready, 0);
    chk("pre-reset err", err, 1);
    #2 arst_n = 0;
    #1;
    chk("async valid", bus.valid, 0);
    chk("async vec_cnt", vec_cnt, 0);
    chk("async err", err, 0);
    chk("async X", xp(), 0);
    model_reset();
    @(negedge clk);
    arst_n = 1;
    got_q.delete();
    g_rdy = 1;
    send_frame(32'h41424344);
    idle(2);
    chk("post-reset delivered", got_q.size(), 1);
    if (got_q.size() == 1) chk("post-reset data", got_q[0], 32'h41424344);
    chk("post-reset vec_cnt", vec_cnt, 1);

    // randomized traffic against the frame-level model
    do_reset();
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      dv   = ($urandom % 4) != 0;
      last = (($urandom % 25) == 0) ? 1'($urandom % 2) : (pos == 3);
      a    = dv && bus.din_ready;
      cycle(dv, 8'($urandom), last, ($urandom % 3) != 0, ($urandom % 16) == 0);
      check_model("rand");
      if (a) pos = last ? 0 : ((pos == 3) ? 3 : pos + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
